feedback_tx: RTL and testbench

- Transmit side of the UAC2 asynchronous feedback path.
- On each SOF, captures the per-SOF cycle count from the feedback counter and scales it into a 32-bit feedback word.
- Writes the word as a 4-byte little-endian packet into the FX2LP slave FIFO (feedback IN endpoint), then commits it with PKTEND.
- Sits between the feedback counter and the FX2LP FIFO bus arbiter.

---
 rtl/feedback_pkg.sv | 20 ++
 rtl/pos_edge_det.sv | 24 ++
 rtl/feedback_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_feedback_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feedback_pkg.sv
// Shared definitions for the UAC2 feedback transmit path.
// Holds the packet geometry and the transmit FSM encoding used by feedback_tx.
package feedback_pkg;

  // Feedback word width and the number of FIFO bytes it occupies.
  localparam int FB_WORD_W = 32;
  localparam int FB_BYTES  = 4;

  // Byte counter runs 0..FB_BYTES, so it needs one value beyond the last index.
  localparam int                IDX_W    = $clog2(FB_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(FB_BYTES);

  // Transmit FSM: the state names what the registered outputs show this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    END  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/pos_edge_det.sv
// Rising-edge detector: one-cycle registered pulse in the cycle after d is
// first sampled high.
module pos_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Keep the previous sample and flag a 0->1 transition one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking so d_q still holds the old sample when pulse is computed.
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end

endmodule

// File: rtl/feedback_tx.sv
// Transmit side of the UAC2 asynchronous feedback path.
// Each SOF captures the per-SOF cycle count, scales it into a 32-bit feedback
// word and writes it as a 4-byte little-endian packet into the FX2LP slave
// FIFO, followed by a one-cycle PKTEND commit.
// Optional build macro FEEDBACK_AVG_EN: average the count over 2^AVG_LOG2 SOFs
// and emit one packet per window instead of one per SOF.
module feedback_tx
  import feedback_pkg::*;
#(
  parameter int FB_SHIFT = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic [15:0] count,
  input  logic        full_n,
  output logic [7:0]  fd,
  output logic        slwr_n,
  output logic        pktend_n,
  output logic        busy,
  output logic        overrun
);

  // Reject parameter values the datapath is not sized for.
  if (FB_SHIFT < 0 || FB_SHIFT > 16 || AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_params
    $error("feedback_tx: FB_SHIFT must be 0..16 and AVG_LOG2 1..4");
  end

  // ---------------------------------------------------------------------------
  // SOF edge detection
  // ---------------------------------------------------------------------------
  logic sof_pulse;

  pos_edge_det u_sof_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sof),
    .pulse (sof_pulse)
  );

  // ---------------------------------------------------------------------------
  // Capture: produce a new feedback word (cap_valid/cap_word)
  // ---------------------------------------------------------------------------
  logic                 cap_valid;
  logic [FB_WORD_W-1:0] cap_word;

`ifdef FEEDBACK_AVG_EN
  logic [19:0]         acc_q;
  logic [19:0]         acc_sum;
  logic [AVG_LOG2-1:0] win_q;

  // Running sum including this SOF; the word is emitted on the last SOF of a window.
  always_comb begin
    acc_sum   = acc_q + 20'(count);
    cap_valid = sof_pulse && (win_q == '1);
    cap_word  = ({12'd0, acc_sum} << FB_SHIFT) >> AVG_LOG2;
  end

  // Accumulate every SOF; clear the sum when a window completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      win_q <= '0;
    end else if (sof_pulse) begin
      win_q <= win_q + 1'b1;
      acc_q <= cap_valid ? 20'd0 : acc_sum;
    end
  end
`else
  // Every SOF produces a word directly from the count.
  always_comb begin
    cap_valid = sof_pulse;
    cap_word  = {16'd0, count} << FB_SHIFT;
  end
`endif

  // ---------------------------------------------------------------------------
  // Pending-word slot between capture and the transmit FSM
  // ---------------------------------------------------------------------------
  logic                 pend_valid_q;
  logic                 pend_valid_d;
  logic [FB_WORD_W-1:0] pend_word_q;
  logic                 consume;

  // A capture always wins over a same-cycle load, leaving the new word pending.
  always_comb begin
    pend_valid_d = pend_valid_q;
    if (consume)   pend_valid_d = 1'b0;
    if (cap_valid) pend_valid_d = 1'b1;
  end

  // Store the newest word; flag overrun when an unconsumed word is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      // NOTE: data registers are reset too so fd never carries X after reset.
      pend_word_q  <= '0;
      overrun      <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      if (cap_valid) begin
        pend_word_q <= cap_word;
      end
      if (cap_valid && pend_valid_q && !consume) begin
        overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_t            state_q;
  tx_state_t            state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [FB_WORD_W-1:0] shreg_q;
  logic [FB_WORD_W-1:0] shreg_d;
  logic                 wr;
  logic [7:0]           wr_byte;

  // State register: FSM state, bytes written so far, and the outgoing shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic. Decisions are taken at the edge that starts the cycle they
  // show, so the first byte is written in the same edge that loads the word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    consume = 1'b0;
    wr      = 1'b0;
    wr_byte = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          consume = 1'b1;
          state_d = SEND;
          if (full_n) begin
            wr      = 1'b1;
            wr_byte = pend_word_q[7:0];
            shreg_d = pend_word_q >> 8;
            idx_d   = IDX_W'(1);
          end else begin
            shreg_d = pend_word_q;
            idx_d   = '0;
          end
        end
      end
      SEND: begin
        if (idx_q == IDX_DONE) begin
          state_d = END;
        end else if (full_n) begin
          wr      = 1'b1;
          wr_byte = shreg_q[7:0];
          shreg_d = shreg_q >> 8;
          idx_d   = idx_q + 1'b1;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [7:0] fd_d;
  logic       slwr_n_d;
  logic       pktend_n_d;
  logic       busy_d;

  // Output decode for the coming cycle; fd holds its value through stalls.
  always_comb begin
    fd_d       = fd;
    slwr_n_d   = 1'b1;
    pktend_n_d = 1'b1;
    if (wr) begin
      fd_d     = wr_byte;
      slwr_n_d = 1'b0;
    end
    if (state_d == END) begin
      fd_d       = 8'd0;
      pktend_n_d = 1'b0;
    end
    busy_d = (state_d != IDLE) | pend_valid_d;
  end

  // Register every output so the FIFO bus sees clean, glitch-free strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fd       <= 8'd0;
      slwr_n   <= 1'b1;
      pktend_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      fd       <= fd_d;
      slwr_n   <= slwr_n_d;
      pktend_n <= pktend_n_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_feedback_tx.sv
// Directed self-checking bench for feedback_tx.
// Two instances share stimulus: the default FB_SHIFT=8 and one with FB_SHIFT=16.
// Build with FEEDBACK_AVG_EN defined to exercise the averaging variant instead.
module tb_feedback_tx;

  logic        clk;
  logic        rst_n;
  logic        sof;
  logic [15:0] count;
  logic        full_n;

  logic [7:0]  fd;
  logic        slwr_n;
  logic        pktend_n;
  logic        busy;
  logic        overrun;

  logic [7:0]  fd16;
  logic        slwr_n16;
  logic        pktend_n16;
  logic        busy16;
  logic        overrun16;

  int checks;
  int failures;

  // Write/commit logs collected on the falling edge.
  logic [7:0] wr_log   [0:255];
  logic [7:0] wr_log16 [0:255];
  int wr_total;
  int wr_total16;
  int pkt_total;
  int pkt_total16;
  int clash;
  int clash16;

  feedback_tx u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .count    (count),
    .full_n   (full_n),
    .fd       (fd),
    .slwr_n   (slwr_n),
    .pktend_n (pktend_n),
    .busy     (busy),
    .overrun  (overrun)
  );

  feedback_tx #(.FB_SHIFT(16)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .count    (count),
    .full_n   (full_n),
    .fd       (fd16),
    .slwr_n   (slwr_n16),
    .pktend_n (pktend_n16),
    .busy     (busy16),
    .overrun  (overrun16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_total    = 0;
    wr_total16  = 0;
    pkt_total   = 0;
    pkt_total16 = 0;
    clash       = 0;
    clash16     = 0;
  end

  always @(negedge clk) begin
    if (!slwr_n) begin
      if (wr_total < 256) wr_log[wr_total] <= fd;
      wr_total <= wr_total + 1;
    end
    if (!pktend_n) pkt_total <= pkt_total + 1;
    if (!slwr_n && !pktend_n) clash <= clash + 1;
    if (!slwr_n16) begin
      if (wr_total16 < 256) wr_log16[wr_total16] <= fd16;
      wr_total16 <= wr_total16 + 1;
    end
    if (!pktend_n16) pkt_total16 <= pkt_total16 + 1;
    if (!slwr_n16 && !pktend_n16) clash16 <= clash16 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise sof for exactly one sampling edge; count stays put afterwards.
  task automatic sof_rise(input logic [15:0] c);
    count = c;
    sof   = 1'b1;
    tick();
    sof   = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] b);
    check({tag, "_slwr"}, 32'(slwr_n), 32'd0);
    check({tag, "_fd"}, 32'(fd), 32'(b));
  endtask

  task automatic check_log(input string tag, input bit wide, input int base, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = wide ? wr_log16[base + i] : wr_log[base + i];
      check($sformatf("%s_b%0d", tag, i), 32'(got), 32'(word[8*i +: 8]));
    end
  endtask

  initial begin
    int base;
    int base16;
    int pbase;
    int pbase16;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sof      = 1'b0;
    count    = 16'd0;
    full_n   = 1'b1;

    // Reset values
    ticks(2);
    check("rst_fd",       32'(fd),       32'd0);
    check("rst_slwr",     32'(slwr_n),   32'd1);
    check("rst_pktend",   32'(pktend_n), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    rst_n = 1'b1;
    ticks(2);

`ifdef FEEDBACK_AVG_EN
    // Four SOFs 100..103 -> one packet (406<<8)>>2 = 0x6580 after the 4th only
    base    = wr_total;
    base16  = wr_total16;
    pbase   = pkt_total;
    for (int k = 0; k < 3; k++) begin
      sof_rise(16'(100 + k));
      ticks(4);
      check($sformatf("avg_nowrite_%0d", k), 32'(wr_total - base), 32'd0);
      check($sformatf("avg_busy_%0d", k), 32'(busy), 32'd0);
    end
    sof_rise(16'd103);
    ticks(10);
    check("avg_writes",  32'(wr_total - base),   32'd4);
    check("avg_pkts",    32'(pkt_total - pbase), 32'd1);
    check_log("avg_word",   1'b0, base,   32'h0000_6580);
    check_log("avg_word16", 1'b1, base16, 32'h0065_8000);
    check("avg_overrun", 32'(overrun), 32'd0);
`else
    // Single packet, cycle exact: 00,70,17,00 then pktend, busy drops after
    sof_rise(16'h1770);
    check("t1_c1_slwr", 32'(slwr_n), 32'd1);
    tick();
    check("t1_c2_slwr", 32'(slwr_n), 32'd1);
    check("t1_c2_busy", 32'(busy),   32'd1);
    tick();
    expect_write("t1_b0", 8'h00);
    tick();
    expect_write("t1_b1", 8'h70);
    tick();
    expect_write("t1_b2", 8'h17);
    tick();
    expect_write("t1_b3", 8'h00);
    tick();
    check("t1_pktend", 32'(pktend_n), 32'd0);
    check("t1_end_slwr", 32'(slwr_n), 32'd1);
    check("t1_end_busy", 32'(busy),   32'd1);
    tick();
    check("t1_post_pktend", 32'(pktend_n), 32'd1);
    check("t1_post_busy",   32'(busy),     32'd0);
    ticks(2);

    // Stall for 5 cycles after byte1
    base  = wr_total;
    pbase = pkt_total;
    sof_rise(16'h1770);
    ticks(2);
    expect_write("t2_b0", 8'h00);
    tick();
    expect_write("t2_b1", 8'h70);
    full_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t2_stall%0d_slwr", k), 32'(slwr_n), 32'd1);
      check($sformatf("t2_stall%0d_fd", k),   32'(fd),     32'h70);
    end
    full_n = 1'b1;
    tick();
    expect_write("t2_b2", 8'h17);
    tick();
    expect_write("t2_b3", 8'h00);
    tick();
    check("t2_pktend", 32'(pktend_n), 32'd0);
    ticks(3);
    check("t2_writes", 32'(wr_total - base),   32'd4);
    check("t2_pkts",   32'(pkt_total - pbase), 32'd1);

    // Two SOFs two cycles apart: 100<<8 then 200<<8, no overrun
    base  = wr_total;
    pbase = pkt_total;
    sof_rise(16'd100);
    tick();
    sof_rise(16'd200);
    ticks(16);
    check("t3_writes",  32'(wr_total - base),   32'd8);
    check("t3_pkts",    32'(pkt_total - pbase), 32'd2);
    check_log("t3_p1", 1'b0, base,     32'h0000_6400);
    check_log("t3_p2", 1'b0, base + 4, 32'h0000_C800);
    check("t3_overrun", 32'(overrun), 32'd0);

    // Three SOFs while the packet is stalled: only the last pending is sent
    base  = wr_total;
    pbase = pkt_total;
    full_n = 1'b0;
    sof_rise(16'h0101);
    ticks(2);
    sof_rise(16'h0A0A);
    tick();
    check("t4_overrun_a", 32'(overrun), 32'd0);
    sof_rise(16'h0B0B);
    tick();
    check("t4_overrun_b", 32'(overrun), 32'd1);
    sof_rise(16'h0C0C);
    tick();
    check("t4_busy",      32'(busy),    32'd1);
    check("t4_nowrite",   32'(wr_total - base), 32'd0);
    full_n = 1'b1;
    ticks(20);
    check("t4_writes",  32'(wr_total - base),   32'd8);
    check("t4_pkts",    32'(pkt_total - pbase), 32'd2);
    check_log("t4_p1", 1'b0, base,     32'h0001_0100);
    check_log("t4_p2", 1'b0, base + 4, 32'h000C_0C00);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Reset after byte1: immediate reset values, no pktend, then a clean packet
    pbase = pkt_total;
    sof_rise(16'h1770);
    ticks(2);
    expect_write("t5_b0", 8'h00);
    tick();
    expect_write("t5_b1", 8'h70);
    rst_n = 1'b0;
    #1;
    check("t5_rst_fd",      32'(fd),       32'd0);
    check("t5_rst_slwr",    32'(slwr_n),   32'd1);
    check("t5_rst_pktend",  32'(pktend_n), 32'd1);
    check("t5_rst_busy",    32'(busy),     32'd0);
    check("t5_rst_overrun", 32'(overrun),  32'd0);
    ticks(3);
    check("t5_no_pktend", 32'(pkt_total - pbase), 32'd0);
    rst_n = 1'b1;
    tick();
    base  = wr_total;
    pbase = pkt_total;
    sof_rise(16'h1234);
    ticks(10);
    check("t5_writes", 32'(wr_total - base),   32'd4);
    check("t5_pkts",   32'(pkt_total - pbase), 32'd1);
    check_log("t5_word", 1'b0, base, 32'h0012_3400);

    // Full-scale count with both shift settings
    base    = wr_total;
    base16  = wr_total16;
    pbase16 = pkt_total16;
    sof_rise(16'hFFFF);
    ticks(10);
    check_log("t6_shift8",  1'b0, base,   32'h00FF_FF00);
    check_log("t6_shift16", 1'b1, base16, 32'hFFFF_0000);
    check("t6_writes16", 32'(wr_total16 - base16),  32'd4);
    check("t6_pkts16",   32'(pkt_total16 - pbase16), 32'd1);
`endif

    // Strobes never overlap
    check("strobe_excl",   32'(clash),   32'd0);
    check("strobe_excl16", 32'(clash16), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
